// File: rtl/cpu6_csr_pkg.sv
// Shared constants for the cpu6 machine-mode CSR file and trap controller:
// CSR addresses, mstatus/mip bit positions, cause codes and mtvec modes.
package cpu6_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIP_MTI_BIT  = 7;
  localparam int MIP_LCL_BASE = 16;

  localparam logic [4:0] CAUSE_MTI      = 5'd7;
  localparam logic [4:0] CAUSE_LCL_BASE = 5'd16;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

  function automatic logic csr_is_known(input logic [11:0] idx);
    case (idx)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu6_csr_irq_arb.sv
// Interrupt side of the CSR file: registers the raw interrupt levels into mip,
// masks them with mie and picks the highest-priority pending cause.
module cpu6_csr_irq_arb
  import cpu6_csr_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tmr_irq_r,
  input  logic [NUM_IRQ-1:0] lcl_irq,
  input  logic [XLEN-1:0]    mie_reg,
  input  logic               global_mie,
  output logic [XLEN-1:0]    mip,
  output logic               irq_req,
  output logic [4:0]         irq_cause
);

  logic               tmr_q;
  logic [NUM_IRQ-1:0] lcl_q;
  logic [XLEN-1:0]    pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= 1'b0;
      lcl_q <= '0;
    end else begin
      tmr_q <= tmr_irq_r;
      lcl_q <= lcl_irq;
    end
  end

  always_comb begin
    mip                            = '0;
    mip[MIP_MTI_BIT]               = tmr_q;
    mip[MIP_LCL_BASE +: NUM_IRQ]   = lcl_q;
  end

  assign pending = mip & mie_reg;
  assign irq_req = global_mie & (|pending);

  // Scan from lowest priority upward so the lowest-numbered local line wins.
  always_comb begin
    irq_cause = CAUSE_MTI;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[MIP_LCL_BASE + i]) begin
        irq_cause = CAUSE_LCL_BASE + 5'(i);
      end
    end
  end

endmodule

// File: rtl/cpu6_csr_trap.sv
// Machine-mode CSR file and trap controller for cpu6: CSR access, trap entry,
// mret return, mcycle and the trap target PC handed to fetch.
module cpu6_csr_trap
  import cpu6_csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_rd_en,
  input  logic               csr_wr_en,
  input  logic [11:0]        csr_idx,
  input  logic [XLEN-1:0]    csr_write_dat,
  output logic [XLEN-1:0]    csr_read_dat,
  output logic               csr_illegal,
  input  logic               tmr_irq_r,
  input  logic [NUM_IRQ-1:0] lcl_irq,
  input  logic               excp_ena,
  input  logic [4:0]         excp_code,
  input  logic [XLEN-1:0]    excp_mepc,
  input  logic [XLEN-1:0]    excp_mtval,
  output logic               irq_req,
  input  logic               irq_ack,
  input  logic [XLEN-1:0]    irq_mepc,
  input  logic               mret_ena,
  output logic [XLEN-1:0]    trap_pc,
  output logic [XLEN-1:0]    csr_mepc
);

  localparam logic [XLEN-1:0] MIE_MASK =
    (XLEN'(1) << MIP_MTI_BIT) | (((XLEN'(1) << NUM_IRQ) - XLEN'(1)) << MIP_LCL_BASE);

  logic             st_mie;
  logic             st_mpie;
  logic [XLEN-1:0]  mie_reg;
  logic [XLEN-3:0]  mtvec_base;
  mtvec_mode_e      mtvec_mode;
  logic [XLEN-1:0]  mscratch;
  logic [XLEN-1:0]  mepc;
  logic [XLEN-1:0]  mcause;
  logic [XLEN-1:0]  mtval;
  logic [63:0]      mcycle;

  logic [XLEN-1:0]  mip;
  logic [4:0]       irq_cause;
  logic [XLEN-1:0]  mstatus_rd;
  logic [XLEN-1:0]  base_pc;
  logic             wr_ok;
  logic             irq_take;

  cpu6_csr_irq_arb #(
    .XLEN    (XLEN),
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_arb (
    .clk        (clk),
    .reset      (reset),
    .tmr_irq_r  (tmr_irq_r),
    .lcl_irq    (lcl_irq),
    .mie_reg    (mie_reg),
    .global_mie (st_mie),
    .mip        (mip),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause)
  );

  assign csr_illegal = (csr_rd_en | csr_wr_en) &
                       (~csr_is_known(csr_idx) | (csr_wr_en & (csr_idx == CSR_MIP)));
  assign wr_ok       = csr_wr_en & ~csr_illegal;
  assign irq_take    = irq_ack & irq_req & ~excp_ena;
  assign csr_mepc    = mepc;

  always_comb begin
    mstatus_rd                                = '0;
    mstatus_rd[MSTATUS_MIE]                   = st_mie;
    mstatus_rd[MSTATUS_MPIE]                  = st_mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    csr_read_dat = '0;
    if (!csr_illegal) begin
      case (csr_idx)
        CSR_MSTATUS:  csr_read_dat = mstatus_rd;
        CSR_MIE:      csr_read_dat = mie_reg;
        CSR_MTVEC:    csr_read_dat = {mtvec_base, mtvec_mode};
        CSR_MSCRATCH: csr_read_dat = mscratch;
        CSR_MEPC:     csr_read_dat = mepc;
        CSR_MCAUSE:   csr_read_dat = mcause;
        CSR_MTVAL:    csr_read_dat = mtval;
        CSR_MIP:      csr_read_dat = mip;
        CSR_MCYCLE:   csr_read_dat = mcycle[31:0];
        CSR_MCYCLEH:  csr_read_dat = mcycle[63:32];
        default:      csr_read_dat = '0;
      endcase
    end
  end

  // Exceptions always vector to the base; only an offered interrupt is vectored.
  assign base_pc = {mtvec_base, 2'b00};
  always_comb begin
    trap_pc = base_pc;
    if (!excp_ena && irq_req && (mtvec_mode == MTVEC_VECTORED)) begin
      trap_pc = base_pc + XLEN'({irq_cause, 2'b00});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_reg    <= '0;
      mtvec_base <= MTVEC_RESET[XLEN-1:2];
      mtvec_mode <= mtvec_mode_e'(MTVEC_RESET[1:0]);
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
      mcycle     <= '0;
    end else begin
      // Trap entry owns mstatus/mepc/mcause/mtval; CSR writes to them lose.
      if (excp_ena) begin
        mepc    <= excp_mepc;
        mcause  <= {{(XLEN-5){1'b0}}, excp_code};
        mtval   <= excp_mtval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (irq_take) begin
        mepc    <= irq_mepc;
        mcause  <= {1'b1, {(XLEN-6){1'b0}}, irq_cause};
        mtval   <= '0;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else begin
        if (mret_ena) begin
          st_mie  <= st_mpie;
          st_mpie <= 1'b1;
        end else if (wr_ok && (csr_idx == CSR_MSTATUS)) begin
          st_mie  <= csr_write_dat[MSTATUS_MIE];
          st_mpie <= csr_write_dat[MSTATUS_MPIE];
        end
        if (wr_ok) begin
          case (csr_idx)
            CSR_MEPC:   mepc   <= {csr_write_dat[XLEN-1:1], 1'b0};
            CSR_MCAUSE: mcause <= csr_write_dat;
            CSR_MTVAL:  mtval  <= csr_write_dat;
            default: ;
          endcase
        end
      end

      if (wr_ok) begin
        case (csr_idx)
          CSR_MIE:      mie_reg  <= csr_write_dat & MIE_MASK;
          CSR_MSCRATCH: mscratch <= csr_write_dat;
          CSR_MTVEC: begin
            mtvec_base <= csr_write_dat[XLEN-1:2];
            if (csr_write_dat[1] == 1'b0) begin
              mtvec_mode <= mtvec_mode_e'(csr_write_dat[1:0]);
            end
          end
          default: ;
        endcase
      end

      if (wr_ok && (csr_idx == CSR_MCYCLE)) begin
        mcycle <= {mcycle[63:32], csr_write_dat};
      end else if (wr_ok && (csr_idx == CSR_MCYCLEH)) begin
        mcycle <= {csr_write_dat, mcycle[31:0]};
      end else begin
        mcycle <= mcycle + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu6_csr_trap.sv
// Directed testbench for cpu6_csr_trap: a table of CSR read/write vectors
// followed by hand-written trap, priority, mcycle and reset sequences.
module tb_cpu6_csr_trap;
  import cpu6_csr_pkg::*;

  localparam int NUM_IRQ = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               csr_rd_en = 1'b0;
  logic               csr_wr_en = 1'b0;
  logic [11:0]        csr_idx = '0;
  logic [31:0]        csr_write_dat = '0;
  logic [31:0]        csr_read_dat;
  logic               csr_illegal;
  logic               tmr_irq_r = 1'b0;
  logic [NUM_IRQ-1:0] lcl_irq = '0;
  logic               excp_ena = 1'b0;
  logic [4:0]         excp_code = '0;
  logic [31:0]        excp_mepc = '0;
  logic [31:0]        excp_mtval = '0;
  logic               irq_req;
  logic               irq_ack = 1'b0;
  logic [31:0]        irq_mepc = '0;
  logic               mret_ena = 1'b0;
  logic [31:0]        trap_pc;
  logic [31:0]        csr_mepc;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_wr;
    logic [11:0] idx;
    logic [31:0] dat;
    logic        exp_ill;
    logic        chk_rdat;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs[40];
  int   num_vecs = 0;

  cpu6_csr_trap #(
    .XLEN        (32),
    .NUM_IRQ     (NUM_IRQ),
    .MTVEC_RESET (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_rd_en     (csr_rd_en),
    .csr_wr_en     (csr_wr_en),
    .csr_idx       (csr_idx),
    .csr_write_dat (csr_write_dat),
    .csr_read_dat  (csr_read_dat),
    .csr_illegal   (csr_illegal),
    .tmr_irq_r     (tmr_irq_r),
    .lcl_irq       (lcl_irq),
    .excp_ena      (excp_ena),
    .excp_code     (excp_code),
    .excp_mepc     (excp_mepc),
    .excp_mtval    (excp_mtval),
    .irq_req       (irq_req),
    .irq_ack       (irq_ack),
    .irq_mepc      (irq_mepc),
    .mret_ena      (mret_ena),
    .trap_pc       (trap_pc),
    .csr_mepc      (csr_mepc)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic is_wr, input logic [11:0] idx, input logic [31:0] dat,
                        input logic exp_ill, input logic chk_rdat, input logic [31:0] exp_rdat);
    vecs[num_vecs] = '{is_wr, idx, dat, exp_ill, chk_rdat, exp_rdat};
    num_vecs++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts a new cycle at the falling edge with event strobes cleared.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [11:0] idx,
                               input logic [31:0] dat);
    @(negedge clk);
    csr_rd_en     = rd;
    csr_wr_en     = wr;
    csr_idx       = idx;
    csr_write_dat = dat;
    excp_ena      = 1'b0;
    irq_ack       = 1'b0;
    mret_ena      = 1'b0;
    #2;
  endtask

  task automatic readCsr(input string name, input logic [11:0] idx, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, idx, 32'h0);
    checkOutput(name, csr_read_dat, exp);
  endtask

  task automatic writeCsr(input logic [11:0] idx, input logic [31:0] dat);
    applyStimulus(1'b0, 1'b1, idx, dat);
  endtask

  initial begin
    addVec(0, CSR_MSTATUS,  0, 0, 1, 32'h0000_1800);
    addVec(0, CSR_MIE,      0, 0, 1, 32'h0);
    addVec(0, CSR_MTVEC,    0, 0, 1, 32'h0000_0100);
    addVec(0, CSR_MSCRATCH, 0, 0, 1, 32'h0);
    addVec(0, CSR_MEPC,     0, 0, 1, 32'h0);
    addVec(0, CSR_MCAUSE,   0, 0, 1, 32'h0);
    addVec(0, CSR_MTVAL,    0, 0, 1, 32'h0);
    addVec(0, CSR_MIP,      0, 0, 1, 32'h0);
    addVec(1, CSR_MIP,      32'hFFFF_FFFF, 1, 1, 32'h0);
    addVec(0, CSR_MIP,      0, 0, 1, 32'h0);
    addVec(0, 12'h123,      0, 1, 1, 32'h0);
    addVec(1, 12'h7C0,      32'h1, 1, 0, 32'h0);
    addVec(1, CSR_MSCRATCH, 32'hDEAD_BEEF, 0, 0, 32'h0);
    addVec(0, CSR_MSCRATCH, 0, 0, 1, 32'hDEAD_BEEF);
    addVec(1, CSR_MEPC,     32'h0000_1235, 0, 0, 32'h0);
    addVec(0, CSR_MEPC,     0, 0, 1, 32'h0000_1234);
    addVec(1, CSR_MTVEC,    32'h0000_1001, 0, 0, 32'h0);
    addVec(0, CSR_MTVEC,    0, 0, 1, 32'h0000_1001);
    addVec(1, CSR_MTVEC,    32'h0000_2002, 0, 0, 32'h0);
    addVec(0, CSR_MTVEC,    0, 0, 1, 32'h0000_2001);
    addVec(1, CSR_MTVEC,    32'h0000_0100, 0, 0, 32'h0);
    addVec(0, CSR_MTVEC,    0, 0, 1, 32'h0000_0100);
    addVec(1, CSR_MIE,      32'hFFFF_FFFF, 0, 0, 32'h0);
    addVec(0, CSR_MIE,      0, 0, 1, 32'h000F_0080);
    addVec(1, CSR_MIE,      32'h0, 0, 0, 32'h0);
    addVec(1, CSR_MSTATUS,  32'hFFFF_FFFF, 0, 0, 32'h0);
    addVec(0, CSR_MSTATUS,  0, 0, 1, 32'h0000_1888);
    addVec(1, CSR_MSTATUS,  32'h0, 0, 0, 32'h0);
    addVec(0, CSR_MSTATUS,  0, 0, 1, 32'h0000_1800);
    addVec(1, CSR_MCAUSE,   32'h8000_000B, 0, 0, 32'h0);
    addVec(0, CSR_MCAUSE,   0, 0, 1, 32'h8000_000B);
    addVec(1, CSR_MTVAL,    32'h0000_0055, 0, 0, 32'h0);
    addVec(0, CSR_MTVAL,    0, 0, 1, 32'h0000_0055);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < num_vecs; i++) begin
      applyStimulus(~vecs[i].is_wr, vecs[i].is_wr, vecs[i].idx, vecs[i].dat);
      checkOutput($sformatf("v%0d_ill_%03h", i, vecs[i].idx), {31'b0, csr_illegal},
                  {31'b0, vecs[i].exp_ill});
      if (vecs[i].chk_rdat) begin
        checkOutput($sformatf("v%0d_rd_%03h", i, vecs[i].idx), csr_read_dat, vecs[i].exp_rdat);
      end
    end

    // Timer interrupt: entry, state capture and mret.
    writeCsr(CSR_MIE, 32'h0000_0080);
    writeCsr(CSR_MSTATUS, 32'h0000_0008);
    applyStimulus(0, 0, 12'h0, 32'h0);
    tmr_irq_r = 1'b1;
    #1;
    checkOutput("tmr_req_before_reg", {31'b0, irq_req}, 32'h0);
    applyStimulus(0, 0, 12'h0, 32'h0);
    checkOutput("tmr_req_after_reg", {31'b0, irq_req}, 32'h1);
    irq_ack  = 1'b1;
    irq_mepc = 32'h0000_2000;
    #1;
    checkOutput("tmr_trap_pc_direct", trap_pc, 32'h0000_0100);
    applyStimulus(0, 0, 12'h0, 32'h0);
    checkOutput("tmr_mepc", csr_mepc, 32'h0000_2000);
    checkOutput("tmr_req_masked", {31'b0, irq_req}, 32'h0);
    readCsr("tmr_mcause", CSR_MCAUSE, 32'h8000_0007);
    readCsr("tmr_mtval", CSR_MTVAL, 32'h0);
    readCsr("tmr_mstatus", CSR_MSTATUS, 32'h0000_1880);
    applyStimulus(0, 0, 12'h0, 32'h0);
    mret_ena = 1'b1;
    #1;
    readCsr("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
    checkOutput("mret_req_back", {31'b0, irq_req}, 32'h1);

    // Vectored mode with local line 2 outranking the timer.
    writeCsr(CSR_MTVEC, 32'h0000_1001);
    writeCsr(CSR_MIE, 32'h0004_0080);
    applyStimulus(0, 0, 12'h0, 32'h0);
    lcl_irq = 4'b0100;
    #1;
    applyStimulus(0, 0, 12'h0, 32'h0);
    checkOutput("vec_req", {31'b0, irq_req}, 32'h1);
    checkOutput("vec_trap_pc_lcl2", trap_pc, 32'h0000_1048);
    readCsr("vec_mip", CSR_MIP, 32'h0004_0080);
    lcl_irq = 4'b0000;
    applyStimulus(0, 0, 12'h0, 32'h0);
    checkOutput("vec_trap_pc_tmr", trap_pc, 32'h0000_101C);

    // Exception and interrupt acknowledged together; mscratch write still lands.
    lcl_irq = 4'b0100;
    applyStimulus(0, 0, 12'h0, 32'h0);
    applyStimulus(0, 1, CSR_MSCRATCH, 32'h0000_00AA);
    excp_ena   = 1'b1;
    excp_code  = 5'd2;
    excp_mepc  = 32'h0000_0300;
    excp_mtval = 32'h0000_0077;
    irq_ack    = 1'b1;
    irq_mepc   = 32'h0000_4444;
    #1;
    checkOutput("both_trap_pc", trap_pc, 32'h0000_1000);
    readCsr("both_mcause", CSR_MCAUSE, 32'h0000_0002);
    checkOutput("both_mepc", csr_mepc, 32'h0000_0300);
    readCsr("both_mtval", CSR_MTVAL, 32'h0000_0077);
    readCsr("both_mscratch", CSR_MSCRATCH, 32'h0000_00AA);
    readCsr("both_mip_pending", CSR_MIP, 32'h0004_0080);
    readCsr("both_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // mcycle carry into the high half and write-suppressed increment.
    writeCsr(CSR_MCYCLEH, 32'h0000_0012);
    writeCsr(CSR_MCYCLE, 32'hFFFF_FFFF);
    readCsr("mcyc_written", CSR_MCYCLE, 32'hFFFF_FFFF);
    readCsr("mcyc_wrap", CSR_MCYCLE, 32'h0000_0000);
    readCsr("mcych_carry", CSR_MCYCLEH, 32'h0000_0013);
    writeCsr(CSR_MCYCLE, 32'h0000_0005);
    readCsr("mcyc_load5", CSR_MCYCLE, 32'h0000_0005);
    readCsr("mcyc_inc6", CSR_MCYCLE, 32'h0000_0006);

    // Reset while in a trap returns everything to reset values.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("rst_irq_req", {31'b0, irq_req}, 32'h0);
    checkOutput("rst_mepc", csr_mepc, 32'h0);
    readCsr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    readCsr("rst_mtvec", CSR_MTVEC, 32'h0000_0100);
    readCsr("rst_mie", CSR_MIE, 32'h0);
    readCsr("rst_mcause", CSR_MCAUSE, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
